// File: rtl/rs232_tx_core.sv
// RS-232 transmitter: one-entry holding register feeding an LSB-first shifter with
// optional parity and one or two stop bits. All logic is qualified by a synchronized PLL lock.
module rs232_tx_core #(
  parameter int unsigned CLKS_PER_BIT = 208,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 locked,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 busy
);

  localparam int unsigned     CntW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]      BitMax  = 3'(DATA_BITS - 1);
  localparam logic            StopMax = (STOP_BITS == 2);

  typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [2:0]           bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic                 par_q, par_d;
  logic                 txd_q, txd_d;
  logic                 lock_meta_q, lock_s_q;
  logic                 accept, bit_end, load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
    end else begin
      lock_meta_q <= locked;
      lock_s_q    <= lock_meta_q;
    end
  end

  assign tx_ready = lock_s_q && !hold_full_q;
  assign accept   = tx_valid && tx_ready;
  assign bit_end  = (cnt_q == CntMax);
  assign busy     = (state_q != StIdle) || hold_full_q;
  assign txd      = txd_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = (state_q == StIdle || bit_end) ? '0 : cnt_q + 1'b1;
    bit_d       = bit_q;
    stop_d      = stop_q;
    shift_d     = shift_q;
    par_d       = par_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    load        = 1'b0;
    txd_d       = 1'b1;

    unique case (state_q)
      StIdle: begin
        if (hold_full_q) load = 1'b1;
      end
      StStart: begin
        bit_d = '0;
        if (bit_end) state_d = StData;
      end
      StData: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == BitMax) begin
            state_d = (PARITY != 0) ? StPar : StStop;
            stop_d  = 1'b0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      StPar: begin
        stop_d = 1'b0;
        if (bit_end) state_d = StStop;
      end
      StStop: begin
        if (bit_end) begin
          if (stop_q == StopMax) begin
            // A queued byte starts its frame with no idle gap.
            if (hold_full_q) load = 1'b1;
            else             state_d = StIdle;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (load) begin
      shift_d     = hold_q;
      par_d       = (PARITY == 1) ? ~^hold_q : ^hold_q;
      hold_full_d = 1'b0;
      state_d     = StStart;
      bit_d       = '0;
      stop_d      = 1'b0;
    end

    if (accept) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    // Lock loss truncates any frame and drops the queued byte.
    if (!lock_s_q) begin
      state_d     = StIdle;
      cnt_d       = '0;
      bit_d       = '0;
      stop_d      = 1'b0;
      hold_full_d = 1'b0;
    end

    case (state_d)
      StStart: txd_d = 1'b0;
      StData:  txd_d = shift_d[0];
      StPar:   txd_d = par_d;
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bit_q       <= '0;
      stop_q      <= 1'b0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      par_q       <= 1'b0;
      txd_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      stop_q      <= stop_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      par_q       <= par_d;
      txd_q       <= txd_d;
    end
  end

endmodule

// File: tb/tb_rs232_tx_core.sv
// Bench for rs232_tx_core: four instances (8N1, 8O1, 8E1, 8N2) at 4 clocks per bit share
// the stimulus; each line is recorded cycle by cycle and compared to a frame model.
module tb_rs232_tx_core;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       locked;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic [3:0] txd_v, rdy_v, busy_v;

  int n_cmp = 0;
  int n_bad = 0;

  int    par_t  [4] = '{0, 1, 2, 0};
  int    stop_t [4] = '{1, 1, 1, 2};
  string nm     [4] = '{"8n1", "8o1", "8e1", "8n2"};

  logic [95:0] w [4];
  logic [95:0] bw;
  logic [95:0] rw;

  always #5 clk = ~clk;

  rs232_tx_core #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .locked(locked), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy_v[0]), .txd(txd_v[0]), .busy(busy_v[0]));
  rs232_tx_core #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst_n(rst_n), .locked(locked), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy_v[1]), .txd(txd_v[1]), .busy(busy_v[1]));
  rs232_tx_core #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst_n(rst_n), .locked(locked), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy_v[2]), .txd(txd_v[2]), .busy(busy_v[2]));
  rs232_tx_core #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_8n2 (
    .clk(clk), .rst_n(rst_n), .locked(locked), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy_v[3]), .txd(txd_v[3]), .busy(busy_v[3]));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bit-slot sequence (slot 0 first) for one or two back-to-back frames, idle-high padded.
  function automatic logic [23:0] model(input logic [7:0] d0, input logic [7:0] d1,
                                        input logic two, input int par, input int stops);
    logic [23:0] m;
    logic [7:0]  d;
    int          p;
    m = '1;
    p = 0;
    for (int f = 0; f < (two ? 2 : 1); f++) begin
      d = (f == 0) ? d0 : d1;
      m[p] = 1'b0;
      p++;
      for (int i = 0; i < 8; i++) begin
        m[p] = d[i];
        p++;
      end
      if (par != 0) begin
        m[p] = (par == 2) ? ^d : ~^d;
        p++;
      end
      p += stops;
    end
    return m;
  endfunction

  // Called right at the edge after the accept edge; the first sample is the start bit.
  task automatic record_check(input logic [7:0] d0, input logic two, input logic [7:0] d1);
    logic [23:0] m;
    for (int c = 0; c < 96; c++) begin
      @(negedge clk);
      for (int u = 0; u < 4; u++) w[u][c] = txd_v[u];
      bw[c] = busy_v[0];
      rw[c] = rdy_v[0];
    end
    for (int u = 0; u < 4; u++) begin
      m = model(d0, d1, two, par_t[u], stop_t[u]);
      for (int s = 0; s < 24; s++)
        check_eq($sformatf("%s %02h slot%0d", nm[u], d0, s), 32'(w[u][4*s +: 4]),
                 32'({4{m[s]}}));
    end
    check_eq("ready after load", 32'(rw[0]), 32'h1);
    check_eq("busy last cycle", 32'(bw[two ? 79 : 39]), 32'h1);
    check_eq("busy after frame", 32'(bw[two ? 80 : 40]), 32'h0);
  endtask

  task automatic send_seq(input logic [7:0] d0, input logic two, input logic [7:0] d1);
    @(negedge clk);
    check_eq("ready before offer", 32'(rdy_v), 32'hF);
    tx_data  = d0;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    check_eq("busy on accept", 32'(busy_v), 32'hF);
    check_eq("ready on accept", 32'(rdy_v), 32'h0);
    check_eq("txd on accept", 32'(txd_v), 32'hF);
    if (two) tx_data = d1;
    else     tx_valid = 1'b0;
    @(posedge clk);
    fork
      record_check(d0, two, d1);
      begin
        if (two) begin
          @(posedge clk);
          #1 tx_valid = 1'b0;
        end
      end
    join
  endtask

  task automatic do_reset(input logic keep_valid);
    @(negedge clk);
    rst_n = 1'b0;
    if (!keep_valid) tx_valid = 1'b0;
    #1;
    check_eq("rst txd", 32'(txd_v), 32'hF);
    check_eq("rst ready", 32'(rdy_v), 32'h0);
    check_eq("rst busy", 32'(busy_v), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 check_eq("ready edge1", 32'(rdy_v), 32'h0);
    @(posedge clk);
    #1 check_eq("ready edge2", 32'(rdy_v), 32'hF);
    check_eq("busy idle", 32'(busy_v), 32'h0);
  endtask

  initial begin
    rst_n    = 1'b0;
    locked   = 1'b1;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    #12;

    do_reset(1'b0);
    send_seq(8'hA5, 1'b0, 8'h00);
    do_reset(1'b0);
    send_seq(8'h00, 1'b1, 8'hFF);
    do_reset(1'b0);
    send_seq(8'h07, 1'b0, 8'h00);
    do_reset(1'b0);
    send_seq(8'h3C, 1'b1, 8'hC3);

    // Lock loss during frame slot 3 (data bit 2) of 0x00.
    do_reset(1'b0);
    @(negedge clk);
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    repeat (13) @(posedge clk);
    @(negedge clk);
    check_eq("txd before unlock", 32'(txd_v[0]), 32'h0);
    locked = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("unlock+2 ready", 32'(rdy_v), 32'h0);
    check_eq("unlock+2 busy", 32'(busy_v), 32'hF);
    check_eq("unlock+2 txd", 32'(txd_v[0]), 32'h0);
    @(posedge clk);
    #1;
    check_eq("unlock+3 txd", 32'(txd_v), 32'hF);
    check_eq("unlock+3 ready", 32'(rdy_v), 32'h0);
    check_eq("unlock+3 busy", 32'(busy_v), 32'h0);
    tx_data  = 8'h81;
    tx_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("unlocked no accept", 32'(busy_v), 32'h0);
    tx_valid = 1'b0;
    locked   = 1'b1;
    @(posedge clk);
    #1 check_eq("relock edge1", 32'(rdy_v), 32'h0);
    @(posedge clk);
    #1 check_eq("relock edge2", 32'(rdy_v), 32'hF);
    send_seq(8'h81, 1'b0, 8'h00);

    // Reset mid-frame with tx_valid held high through and after reset.
    @(negedge clk);
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_eq("txd before reset", 32'(txd_v[0]), 32'h0);
    tx_data  = 8'h81;
    tx_valid = 1'b1;
    do_reset(1'b1);
    @(posedge clk);
    #1;
    check_eq("post-reset accept busy", 32'(busy_v), 32'hF);
    check_eq("post-reset accept ready", 32'(rdy_v), 32'h0);
    tx_valid = 1'b0;
    @(posedge clk);
    record_check(8'h81, 1'b0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
